// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared definitions for the UART receive frame controller: FSM encoding,
// default frame parameters and the running-checksum helper.
package uart_rx_frame_ctrl_pkg;

   localparam logic [7:0] DEF_SYNC_BYTE = 8'hAA;
   localparam int         DEF_MAX_LEN   = 16;
   localparam int         DEF_TIMEOUT   = 50000;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_GET_LEN   = 3'd1,
      S_GET_DATA  = 3'd2,
      S_GET_CKSUM = 3'd3,
      S_HOLD      = 3'd4
   } state_t;

   function automatic logic [7:0] cksum_add(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte-stream input, frame handshake, payload read port and error pulses
// of the UART receive frame controller.
interface uart_rx_frame_ctrl_if;

   logic [7:0] RX_DATA;
   logic       RX_RECV;
   logic       FRAME_VALID;
   logic       FRAME_READY;
   logic [4:0] FRAME_LEN;
   logic [3:0] RD_ADDR;
   logic [7:0] RD_DATA;
   logic       BUSY;
   logic       ERR_CKSUM;
   logic       ERR_LEN;
   logic       ERR_TIMEOUT;
   logic       ERR_OVERRUN;

   modport slave (
      input  RX_DATA, RX_RECV, FRAME_READY, RD_ADDR,
      output FRAME_VALID, FRAME_LEN, RD_DATA, BUSY,
             ERR_CKSUM, ERR_LEN, ERR_TIMEOUT, ERR_OVERRUN
   );

   modport master (
      output RX_DATA, RX_RECV, FRAME_READY, RD_ADDR,
      input  FRAME_VALID, FRAME_LEN, RD_DATA, BUSY,
             ERR_CKSUM, ERR_LEN, ERR_TIMEOUT, ERR_OVERRUN
   );

endinterface

// File: rtl/uart_rx_frame_ctrl_frame_buf.sv
// 16x8 payload store: one write port, one registered read port.
// Array contents are intentionally left unreset.
module frame_buf (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       wr_en_i,
   input  logic [3:0] wr_addr_i,
   input  logic [7:0] wr_data_i,
   input  logic [3:0] rd_addr_i,
   output logic [7:0] rd_data_o
);

   logic [7:0] mem_q [16];
   logic [7:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_data_q <= 8'h00;
      end else begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frames a UART byte stream (SYNC, LEN, payload, CKSUM) into a held payload
// buffer with a valid/ready handshake, an inter-byte timeout and error pulses.
module uart_rx_frame_ctrl
   import uart_rx_frame_ctrl_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
   parameter int         MAX_LEN   = DEF_MAX_LEN,
   parameter int         TIMEOUT   = DEF_TIMEOUT
) (
   input logic                 CLK,
   input logic                 RST,
   uart_rx_frame_ctrl_if.slave bus
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t           state_q, state_d;
   logic [4:0]       len_q, len_d;
   logic [3:0]       idx_q, idx_d;
   logic [7:0]       sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             frame_valid_q, frame_valid_d;
   logic             busy_q, busy_d;
   logic             err_cksum_q, err_cksum_d;
   logic             err_len_q, err_len_d;
   logic             err_to_q, err_to_d;
   logic             err_ov_q, err_ov_d;
   logic             wr_en;
   logic             timeout_hit;
   logic [7:0]       rd_data;

   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

   // Next-state logic; a received byte always wins over a same-cycle timeout.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      idx_d       = idx_q;
      sum_d       = sum_q;
      cnt_d       = '0;
      err_cksum_d = 1'b0;
      err_len_d   = 1'b0;
      err_to_d    = 1'b0;
      err_ov_d    = 1'b0;
      wr_en       = 1'b0;

      if (!bus.RX_RECV && (state_q == S_GET_LEN || state_q == S_GET_DATA ||
                           state_q == S_GET_CKSUM)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = '0;
      end

      unique case (state_q)
         S_IDLE: begin
            if (bus.RX_RECV && bus.RX_DATA == SYNC_BYTE) begin
               state_d = S_GET_LEN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GET_LEN: begin
            if (bus.RX_RECV) begin
               if (bus.RX_DATA != 8'd0 && bus.RX_DATA <= 8'(MAX_LEN)) begin
                  len_d   = bus.RX_DATA[4:0];
                  sum_d   = bus.RX_DATA;
                  idx_d   = 4'd0;
                  state_d = S_GET_DATA;
               end else begin
                  err_len_d = 1'b1;
                  state_d   = S_IDLE;
               end
            end else if (timeout_hit) begin
               err_to_d = 1'b1;
               state_d  = S_IDLE;
            end else begin
               state_d = S_GET_LEN;
            end
         end
         S_GET_DATA: begin
            if (bus.RX_RECV) begin
               wr_en = 1'b1;
               sum_d = cksum_add(sum_q, bus.RX_DATA);
               idx_d = idx_q + 4'd1;
               if ({1'b0, idx_q} == len_q - 5'd1) begin
                  state_d = S_GET_CKSUM;
               end else begin
                  state_d = S_GET_DATA;
               end
            end else if (timeout_hit) begin
               err_to_d = 1'b1;
               state_d  = S_IDLE;
            end else begin
               state_d = S_GET_DATA;
            end
         end
         S_GET_CKSUM: begin
            if (bus.RX_RECV) begin
               if (bus.RX_DATA == sum_q) begin
                  state_d = S_HOLD;
               end else begin
                  err_cksum_d = 1'b1;
                  state_d     = S_IDLE;
               end
            end else if (timeout_hit) begin
               err_to_d = 1'b1;
               state_d  = S_IDLE;
            end else begin
               state_d = S_GET_CKSUM;
            end
         end
         S_HOLD: begin
            // Bytes arriving while a frame is held are dropped, buffer untouched.
            err_ov_d = bus.RX_RECV;
            if (frame_valid_q && bus.FRAME_READY) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_HOLD;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      frame_valid_d = (state_d == S_HOLD);
      busy_d        = (state_d != S_IDLE);
   end

   // State, datapath and registered output flops.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q       <= S_IDLE;
         len_q         <= 5'd0;
         idx_q         <= 4'd0;
         sum_q         <= 8'd0;
         cnt_q         <= '0;
         frame_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         err_cksum_q   <= 1'b0;
         err_len_q     <= 1'b0;
         err_to_q      <= 1'b0;
         err_ov_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         len_q         <= len_d;
         idx_q         <= idx_d;
         sum_q         <= sum_d;
         cnt_q         <= cnt_d;
         frame_valid_q <= frame_valid_d;
         busy_q        <= busy_d;
         err_cksum_q   <= err_cksum_d;
         err_len_q     <= err_len_d;
         err_to_q      <= err_to_d;
         err_ov_q      <= err_ov_d;
      end
   end

   frame_buf u_frame_buf (
      .clk_i     (CLK),
      .rst_i     (RST),
      .wr_en_i   (wr_en),
      .wr_addr_i (idx_q),
      .wr_data_i (bus.RX_DATA),
      .rd_addr_i (bus.RD_ADDR),
      .rd_data_o (rd_data)
   );

   assign bus.FRAME_VALID = frame_valid_q;
   assign bus.FRAME_LEN   = len_q;
   assign bus.RD_DATA     = rd_data;
   assign bus.BUSY        = busy_q;
   assign bus.ERR_CKSUM   = err_cksum_q;
   assign bus.ERR_LEN     = err_len_q;
   assign bus.ERR_TIMEOUT = err_to_q;
   assign bus.ERR_OVERRUN = err_ov_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: directed frames plus randomized
// byte streams scored against a frame-parsing reference model.
module tb_uart_rx_frame_ctrl;

   localparam logic [7:0] SYNC = 8'hAA;
   localparam int         MAXL = 16;
   localparam int         TO   = 300;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   uart_rx_frame_ctrl_if bus ();

   uart_rx_frame_ctrl #(.SYNC_BYTE(SYNC), .MAX_LEN(MAXL), .TIMEOUT(TO)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;
   int n_len = 0, n_ck = 0, n_to = 0, n_ov = 0;
   int b_len, b_ck, b_to, b_ov;

   // Count cycles each error pulse is seen high.
   always @(negedge CLK) begin
      if (bus.ERR_LEN     === 1'b1) n_len++;
      if (bus.ERR_CKSUM   === 1'b1) n_ck++;
      if (bus.ERR_TIMEOUT === 1'b1) n_to++;
      if (bus.ERR_OVERRUN === 1'b1) n_ov++;
   end

   logic [7:0] stream_q[$];
   logic [7:0] exp_pay[$];
   int         m_len, m_ck, m_ov;
   bit         m_held;

   task automatic send_byte(input logic [7:0] b);
      bus.RX_DATA = b;
      bus.RX_RECV = 1'b1;
      @(negedge CLK);
      bus.RX_RECV = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic send_stream(input int max_gap);
      foreach (stream_q[k]) begin
         send_byte(stream_q[k]);
         idle($urandom_range(0, max_gap));
      end
   endtask

   task automatic read_byte(input logic [3:0] a, output logic [7:0] d);
      bus.RD_ADDR = a;
      @(negedge CLK);
      d = bus.RD_DATA;
   endtask

   task automatic consume();
      bus.FRAME_READY = 1'b1;
      @(negedge CLK);
      bus.FRAME_READY = 1'b0;
   endtask

   task automatic snap();
      b_len = n_len; b_ck = n_ck; b_to = n_to; b_ov = n_ov;
   endtask

   // Reference: parse the byte list by frame rules into error counts and held payload.
   task automatic model_parse();
      int i;
      int ln;
      logic [7:0] s;
      m_len = 0; m_ck = 0; m_ov = 0; m_held = 1'b0;
      exp_pay.delete();
      i = 0;
      while (i < stream_q.size()) begin
         if (m_held) begin
            m_ov++;
            i++;
         end else if (stream_q[i] != SYNC || i + 1 >= stream_q.size()) begin
            i++;
         end else begin
            ln = int'(stream_q[i+1]);
            if (ln < 1 || ln > MAXL) begin
               m_len++;
               i += 2;
            end else if (i + 2 + ln >= stream_q.size()) begin
               i = stream_q.size();
            end else begin
               s = 8'(ln);
               for (int k = 0; k < ln; k++) s = s + stream_q[i+2+k];
               if (stream_q[i+2+ln] == s) begin
                  m_held = 1'b1;
                  for (int k = 0; k < ln; k++) exp_pay.push_back(stream_q[i+2+k]);
               end else begin
                  m_ck++;
               end
               i += 3 + ln;
            end
         end
      end
   endtask

   // Compare DUT against the model after a stream has been sent.
   task automatic check_model(input string tag);
      logic [7:0] d;
      checks++;
      if (bus.FRAME_VALID !== m_held) begin
         errors++; $display("FAIL %s_valid: got %0b expected %0b", tag, bus.FRAME_VALID, m_held);
      end
      checks++;
      if (bus.BUSY !== m_held) begin
         errors++; $display("FAIL %s_busy: got %0b expected %0b", tag, bus.BUSY, m_held);
      end
      checks++;
      if (n_len - b_len != m_len || n_ck - b_ck != m_ck || n_ov - b_ov != m_ov || n_to != b_to) begin
         errors++;
         $display("FAIL %s_errs: got len=%0d ck=%0d ov=%0d to=%0d expected len=%0d ck=%0d ov=%0d to=0",
                  tag, n_len - b_len, n_ck - b_ck, n_ov - b_ov, n_to - b_to, m_len, m_ck, m_ov);
      end
      if (m_held) begin
         checks++;
         if (bus.FRAME_LEN !== 5'(exp_pay.size())) begin
            errors++; $display("FAIL %s_len: got %0d expected %0d", tag, bus.FRAME_LEN, exp_pay.size());
         end
         for (int k = 0; k < exp_pay.size(); k++) begin
            read_byte(4'(k), d);
            checks++;
            if (d !== exp_pay[k]) begin
               errors++; $display("FAIL %s_data[%0d]: got %02h expected %02h", tag, k, d, exp_pay[k]);
            end
         end
         consume();
         checks++;
         if (bus.FRAME_VALID !== 1'b0 || bus.BUSY !== 1'b0) begin
            errors++; $display("FAIL %s_release: got valid=%0b busy=%0b expected 0 0", tag, bus.FRAME_VALID, bus.BUSY);
         end
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      bus.RX_DATA = 8'h00; bus.RX_RECV = 1'b0; bus.FRAME_READY = 1'b0; bus.RD_ADDR = 4'd0;
      idle(3);
      checks++;
      if ({bus.FRAME_VALID, bus.BUSY, bus.FRAME_LEN} !== 7'd0) begin
         errors++; $display("FAIL reset_outs: got valid=%0b busy=%0b len=%0d expected 0 0 0", bus.FRAME_VALID, bus.BUSY, bus.FRAME_LEN);
      end
      checks++;
      if ({bus.ERR_CKSUM, bus.ERR_LEN, bus.ERR_TIMEOUT, bus.ERR_OVERRUN} !== 4'b0000) begin
         errors++; $display("FAIL reset_errs: got %04b expected 0000", {bus.ERR_CKSUM, bus.ERR_LEN, bus.ERR_TIMEOUT, bus.ERR_OVERRUN});
      end
      RST = 1'b0;
      idle(2);
      checks++;
      if (bus.BUSY !== 1'b0) begin
         errors++; $display("FAIL reset_idle_busy: got %0b expected 0", bus.BUSY);
      end
   endtask

   task automatic test_basic();
      stream_q = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
      model_parse(); snap();
      send_stream(0);
      idle(1);
      checks++;
      if (m_held !== 1'b1) begin
         errors++; $display("FAIL basic_model: got held=%0b expected 1", m_held);
      end
      check_model("basic");
   endtask

   task automatic test_cksum_err();
      snap();
      send_byte(8'hAA); send_byte(8'h02); send_byte(8'h05); send_byte(8'h06); send_byte(8'h00);
      checks++;
      if (bus.ERR_CKSUM !== 1'b1) begin
         errors++; $display("FAIL cksum_pulse_now: got %0b expected 1", bus.ERR_CKSUM);
      end
      idle(2);
      checks++;
      if (n_ck - b_ck != 1 || bus.FRAME_VALID !== 1'b0 || bus.BUSY !== 1'b0) begin
         errors++; $display("FAIL cksum_err: got pulses=%0d valid=%0b busy=%0b expected 1 0 0", n_ck - b_ck, bus.FRAME_VALID, bus.BUSY);
      end
   endtask

   task automatic test_len_err();
      snap();
      send_byte(8'hAA); send_byte(8'h00); send_byte(8'hAA); send_byte(8'h11);
      idle(2);
      checks++;
      if (n_len - b_len != 2 || bus.BUSY !== 1'b0) begin
         errors++; $display("FAIL len_err: got pulses=%0d busy=%0b expected 2 0", n_len - b_len, bus.BUSY);
      end
      stream_q = '{8'h55, 8'hAA, 8'h01, 8'hAA, 8'hAB};
      model_parse(); snap();
      send_stream(1);
      idle(1);
      check_model("sync_in_data");
   endtask

   task automatic test_timeout();
      snap();
      send_byte(8'hAA); send_byte(8'h02); send_byte(8'h01);
      idle(TO + 3);
      checks++;
      if (n_to - b_to != 1 || bus.BUSY !== 1'b0) begin
         errors++; $display("FAIL timeout_expire: got pulses=%0d busy=%0b expected 1 0", n_to - b_to, bus.BUSY);
      end
      snap();
      send_byte(8'hAA); idle(TO);
      idle(2);
      checks++;
      if (n_to - b_to != 1 || bus.BUSY !== 1'b0) begin
         errors++; $display("FAIL timeout_exact: got pulses=%0d busy=%0b expected 1 0", n_to - b_to, bus.BUSY);
      end
      snap();
      send_byte(8'hAA); idle(TO - 1);
      send_byte(8'h02); idle(TO - 1);
      send_byte(8'h01); idle(TO - 10);
      send_byte(8'h02); idle(TO - 1);
      send_byte(8'h05);
      idle(1);
      checks++;
      if (n_to != b_to || bus.FRAME_VALID !== 1'b1) begin
         errors++; $display("FAIL timeout_gap: got pulses=%0d valid=%0b expected 0 1", n_to - b_to, bus.FRAME_VALID);
      end
      consume();
   endtask

   task automatic test_overrun();
      logic [7:0] d;
      send_byte(8'hAA); send_byte(8'h01); send_byte(8'h5A); send_byte(8'h5B);
      idle(1);
      snap();
      send_byte(8'hAA); send_byte(8'h01); send_byte(8'h07); send_byte(8'h08);
      idle(1);
      checks++;
      if (n_ov - b_ov != 4 || bus.FRAME_VALID !== 1'b1 || bus.FRAME_LEN !== 5'd1) begin
         errors++; $display("FAIL overrun_hold: got pulses=%0d valid=%0b len=%0d expected 4 1 1", n_ov - b_ov, bus.FRAME_VALID, bus.FRAME_LEN);
      end
      read_byte(4'd0, d);
      checks++;
      if (d !== 8'h5A) begin
         errors++; $display("FAIL overrun_payload: got %02h expected 5a", d);
      end
      bus.FRAME_READY = 1'b1;
      send_byte(SYNC);
      bus.FRAME_READY = 1'b0;
      idle(1);
      checks++;
      if (n_ov - b_ov != 5 || bus.FRAME_VALID !== 1'b0 || bus.BUSY !== 1'b0) begin
         errors++; $display("FAIL overrun_handshake: got pulses=%0d valid=%0b busy=%0b expected 5 0 0", n_ov - b_ov, bus.FRAME_VALID, bus.BUSY);
      end
   endtask

   task automatic test_reset_mid();
      snap();
      send_byte(8'hAA); send_byte(8'h04); send_byte(8'h12);
      checks++;
      if (bus.BUSY !== 1'b1) begin
         errors++; $display("FAIL rstmid_busy_before: got %0b expected 1", bus.BUSY);
      end
      RST = 1'b1;
      #1;
      checks++;
      if (bus.BUSY !== 1'b0) begin
         errors++; $display("FAIL rstmid_async: got busy=%0b expected 0", bus.BUSY);
      end
      @(negedge CLK);
      RST = 1'b0;
      idle(2);
      checks++;
      if ((n_len - b_len) + (n_ck - b_ck) + (n_to - b_to) + (n_ov - b_ov) != 0) begin
         errors++; $display("FAIL rstmid_noerr: got %0d pulses expected 0", (n_len - b_len) + (n_ck - b_ck) + (n_to - b_to) + (n_ov - b_ov));
      end
      stream_q = '{8'hAA, 8'h01, 8'h42, 8'h43};
      model_parse(); snap();
      send_stream(0);
      idle(1);
      check_model("rstmid_frame");
   endtask

   task automatic test_back_to_back();
      stream_q = '{8'hAA, 8'h20, 8'hAA, 8'h01, 8'h10, 8'h00,
                   8'hAA, 8'h02, 8'hAA, 8'hAA, 8'h56, 8'h33};
      model_parse(); snap();
      send_stream(0);
      idle(1);
      check_model("b2b");
   endtask

   task automatic test_random();
      logic [7:0] b, s;
      int mode, ln;
      for (int it = 0; it < 30; it++) begin
         stream_q.delete();
         repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom_range(0, 255));
            if (b == SYNC) b = 8'h55;
            stream_q.push_back(b);
         end
         stream_q.push_back(SYNC);
         mode = $urandom_range(0, 3);
         if (mode == 3) begin
            stream_q.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)));
         end else begin
            ln = $urandom_range(1, MAXL);
            stream_q.push_back(8'(ln));
            s = 8'(ln);
            for (int k = 0; k < ln; k++) begin
               b = 8'($urandom_range(0, 255));
               stream_q.push_back(b);
               s = s + b;
            end
            if (mode == 2) s = s + 8'($urandom_range(1, 255));
            stream_q.push_back(s);
            if (mode == 1) repeat ($urandom_range(0, 2)) stream_q.push_back(8'($urandom_range(0, 255)));
         end
         model_parse(); snap();
         send_stream(2);
         idle(2);
         check_model("rand");
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_cksum_err();
      test_len_err();
      test_timeout();
      test_overrun();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame_ctrl.md
UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hAA, frame start marker.
REQ-002 SHALL have parameter MAX_LEN, default 16, maximum payload bytes (2..16).
REQ-003 SHALL have parameter TIMEOUT, default 50000, inter-byte timeout in CLK cycles (1 ms at 50 MHz).
REQ-004 SHALL have port CLK  in  1  sole clock; all logic on posedge CLK.
REQ-005 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port RX_DATA  in  8  received byte from the UART receiver.
REQ-007 SHALL have port RX_RECV  in  1  one-cycle strobe; RX_DATA valid in that cycle.
REQ-008 SHALL have port FRAME_VALID  out  1  complete, checksum-good frame held in buffer.
REQ-009 SHALL have port FRAME_READY  in  1  consumer accepts frame.
REQ-010 SHALL have port FRAME_LEN  out  5  payload length of held frame.
REQ-011 SHALL have port RD_ADDR  in  4  payload byte index.
REQ-012 SHALL have port RD_DATA  out  8  payload byte at RD_ADDR, 1-cycle read latency.
REQ-013 SHALL have port BUSY  out  1  high in any state other than IDLE.
REQ-014 SHALL have ports ERR_CKSUM, ERR_LEN, ERR_TIMEOUT, ERR_OVERRUN  out  1 each  one-cycle error pulses.

Function
REQ-015 Frame format SHALL be: SYNC_BYTE, LEN, LEN payload bytes, CKSUM; CKSUM = (LEN + sum of payload) mod 256.
REQ-016 States SHALL be IDLE, GET_LEN, GET_DATA, GET_CKSUM, HOLD.
REQ-017 IDLE: RX_RECV with RX_DATA==SYNC_BYTE -> GET_LEN; any other byte ignored, no error.
REQ-018 GET_LEN: LEN in 1..MAX_LEN -> stored, running sum := LEN, index := 0, -> GET_DATA; else ERR_LEN pulse, -> IDLE.
REQ-019 GET_DATA: each byte written to buffer[index], added to sum (8-bit wrap), index++; after LEN-th byte -> GET_CKSUM.
REQ-020 GET_CKSUM: byte==sum -> HOLD, FRAME_VALID high the next cycle; mismatch -> ERR_CKSUM pulse, -> IDLE.
REQ-021 HOLD: FRAME_VALID and FRAME_LEN stable until FRAME_VALID && FRAME_READY sampled high; then -> IDLE, FRAME_VALID low next cycle.
REQ-022 HOLD: RX_RECV byte SHALL be dropped with ERR_OVERRUN pulse, including in the handshake cycle; buffer never overwritten while FRAME_VALID high.
REQ-023 Timeout counter SHALL clear on entry to GET_LEN and on every RX_RECV; counts in GET_LEN/GET_DATA/GET_CKSUM; at TIMEOUT-1 -> IDLE with ERR_TIMEOUT pulse.
REQ-024 RX_RECV in the same cycle as timeout expiry SHALL take priority (byte processed, counter cleared).
REQ-025 SYNC_BYTE value inside LEN/payload/CKSUM SHALL be treated as data, never as resync.
REQ-026 Error pulses SHALL be registered, one cycle wide, in the cycle after the causing RX_RECV or expiry.
REQ-027 RD_DATA for RD_ADDR >= FRAME_LEN SHALL return stale buffer contents, undefined to consumer.

Reset
REQ-028 RST SHALL force state IDLE, FRAME_VALID=0, FRAME_LEN=0, BUSY=0, all ERR_*=0, counters and sum 0, immediately.
REQ-029 Buffer contents SHALL NOT require reset; RD_DATA after reset is don't-care.
REQ-030 RST mid-frame SHALL discard the partial frame with no error pulse.

Structure
REQ-031 State encodings and default SYNC_BYTE/MAX_LEN/TIMEOUT SHALL live in the shared UART package/include.
REQ-032 Payload storage SHALL be one sub-module, frame_buf: 16x8 single-write, single-read, registered read port.

Verification
REQ-033 Frame AA 03 11 22 33 69 -> FRAME_VALID=1, FRAME_LEN=3, RD_ADDR 0..2 reads 11,22,33; READY=1 -> VALID=0, BUSY=0.
REQ-034 Frame AA 02 05 06 00 -> ERR_CKSUM single pulse, no FRAME_VALID, state IDLE.
REQ-035 AA 00 and AA 11 -> ERR_LEN pulse each; 55 AA 01 AA AB -> valid frame, payload AA, stray 55 ignored.
REQ-036 AA 02 01 then silence 50000 cycles -> ERR_TIMEOUT pulse, BUSY=0; gap of 49990 cycles between bytes -> no timeout.
REQ-037 Valid frame held, READY=0, send AA 01 07 08 -> four ERR_OVERRUN pulses, original payload intact.
REQ-038 RST asserted after AA 04 12 -> BUSY=0, no errors; following AA 01 42 43 -> FRAME_VALID, RD_DATA 42.
